cache_ctrl_fsm: RTL and testbench
=================================

// Module: cache_ctrl_fsm
// PURPOSE
//  Parametrised direct-mapped cache controller FSM. Sits between the CPU request
//  port, the tag/data arrays and the memory port. Successor to the 4-state
//  read-only controller: adds CPU writes and write-through or write-back mode.
//  Also adds an internal block-word counter (no external END) and a req/ack
//  memory handshake.
// PARAMETERS
//  WORDS_PER_BLK  4  words per cache block; power of 2, >=2
//  CNT_W          2  word counter width = log2(WORDS_PER_BLK)
//  WRITE_BACK     0  0 = write-through/no dirty bits; 1 = write-back with dirty eviction
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  cpu_req    in   1      CPU access request, held until cpu_ready
//  cpu_we     in   1      1 = write, 0 = read; stable while cpu_req=1
//  tag_match  in   1      indexed tag equals request tag
//  tag_valid  in   1      indexed line valid bit
//  tag_dirty  in   1      indexed line dirty bit (ignored when WRITE_BACK=0)
//  mem_ack    in   1      memory accepted/returned one word this cycle
//  cpu_ready  out  1      access complete (read data valid / write done)
//  mem_req    out  1      memory request, held until mem_ack
//  mem_we     out  1      memory write (evict / write-through), valid with mem_req
//  word_cnt   out  CNT_W  word offset for block transfers
//  data_we    out  1      data array write strobe
//  data_mux   out  1      data array source: 0 = CPU data, 1 = memory data
//  tag_we     out  1      tag array write strobe
//  valid_set  out  1      set valid bit of indexed line
//  dirty_set  out  1      set dirty bit of indexed line (WRITE_BACK=1 only)
//  dirty_clr  out  1      clear dirty bit of indexed line
//  busy       out  1      1 in every state except LOOKUP
// BEHAVIOUR
//  States (3-bit encoding): LOOKUP, HIT, WTHRU, EVICT, REFILL, UPDATE.
//  Reset: state=LOOKUP, word_cnt=0. All outputs 0 while reset_n=0.
//  hit = tag_match & tag_valid.
//  LOOKUP transitions:
//   - cpu_req=0: stay.
//   - cpu_req & hit: go to HIT.
//   - cpu_req & ~hit & WRITE_BACK & tag_valid & tag_dirty: go to EVICT.
//   - cpu_req & ~hit, otherwise: go to REFILL.
//   - word_cnt is forced to 0 in LOOKUP.
//  HIT (1 cycle): cpu_ready=1.
//   - If cpu_we: data_we=1, data_mux=0.
//   - cpu_we & WRITE_BACK=1: dirty_set=1, then LOOKUP.
//   - cpu_we & WRITE_BACK=0: go to WTHRU.
//   - Read: go to LOOKUP.
//  WTHRU: mem_req=1, mem_we=1, single word. Stay until mem_ack, then LOOKUP.
//   cpu_ready was already given in HIT; the CPU must not issue a new req while busy=1.
//  EVICT: mem_req=1, mem_we=1.
//   - Each mem_ack increments word_cnt.
//   - mem_ack & word_cnt==WORDS_PER_BLK-1: word_cnt wraps to 0, go to REFILL.
//  REFILL: mem_req=1, mem_we=0. data_mux=1 for the whole state.
//   - data_we = mem_ack (Mealy, same cycle as the returned word).
//   - Each mem_ack increments word_cnt.
//   - Last word: word_cnt wraps to 0, go to UPDATE.
//  UPDATE (1 cycle): tag_we=1, valid_set=1, dirty_clr=1, then LOOKUP.
//   The re-lookup then hits, so a write miss is write-allocate.
//  All other outputs are Moore, decoded from state only.
//  Boundaries:
//   - mem_ack outside WTHRU/EVICT/REFILL is ignored.
//   - mem_ack held for consecutive cycles gives one word per cycle.
//   - cpu_req dropping mid-miss does not abort the transfer.
//   - reset_n asserted mid-transfer returns to LOOKUP at once; line stays invalid
//     (tag_we never fired).
//   - With WRITE_BACK=0, dirty_set and dirty_clr are never 1 and EVICT is unreachable.
// TESTING
//  1. Read hit: reset, cpu_req=1, we=0, match=valid=1 -> HIT next cycle,
//     cpu_ready=1 one cycle, no mem_req.
//  2. Read miss, WPB=4, mem_ack every cycle -> REFILL 4 cycles, data_we on
//     word_cnt 0..3, then UPDATE (tag_we=1), LOOKUP, HIT.
//  3. WRITE_BACK=1, dirty miss -> EVICT 4 acks with mem_we=1 and word_cnt 0..3,
//     REFILL 4 acks, UPDATE with dirty_clr=1.
//  4. WRITE_BACK=0 write hit -> HIT (data_we=1, data_mux=0), WTHRU; hold mem_ack=0
//     3 cycles (mem_req stays 1), ack -> LOOKUP.
//  5. Refill with mem_ack gapped (1,0,0,1,1,0,1) -> exactly 4 data_we pulses,
//     word_cnt advances only on acks.
//  6. reset_n low during REFILL word 2 -> state LOOKUP, word_cnt=0, all outputs 0,
//     no tag_we pulse.

Source files
------------

// File: rtl/cache_ctrl_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_fsm
// Description : Direct-mapped cache controller FSM. Handles CPU read/write,
//               write-through or write-back policy, block refill/eviction
//               with an internal word counter and a req/ack memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_fsm #(
    parameter int WORDS_PER_BLK = 4,
    parameter int CNT_W         = 2,
    parameter int WRITE_BACK    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic             tag_match,
    input  logic             tag_valid,
    input  logic             tag_dirty,
    input  logic             mem_ack,
    output logic             cpu_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [CNT_W-1:0] word_cnt,
    output logic             data_we,
    output logic             data_mux,
    output logic             tag_we,
    output logic             valid_set,
    output logic             dirty_set,
    output logic             dirty_clr,
    output logic             busy
);

    localparam logic [2:0] c_LOOKUP = 3'd0;
    localparam logic [2:0] c_HIT    = 3'd1;
    localparam logic [2:0] c_WTHRU  = 3'd2;
    localparam logic [2:0] c_EVICT  = 3'd3;
    localparam logic [2:0] c_REFILL = 3'd4;
    localparam logic [2:0] c_UPDATE = 3'd5;

    localparam logic [CNT_W-1:0] c_LAST_WORD = CNT_W'(WORDS_PER_BLK - 1);
    localparam logic             c_WB        = (WRITE_BACK != 0);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_word_cnt;
    logic             w_hit;
    logic             w_last_ack;

    assign w_hit      = tag_match & tag_valid;
    assign w_last_ack = mem_ack & (r_word_cnt == c_LAST_WORD);
    assign word_cnt   = r_word_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_LOOKUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter only moves on accepted words; the power-of-2 block size makes
    // the natural overflow the wrap back to word 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_cnt <= '0;
        end else if (r_state == c_LOOKUP) begin
            r_word_cnt <= '0;
        end else if (((r_state == c_EVICT) || (r_state == c_REFILL)) && mem_ack) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cpu_ready   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        data_we     = 1'b0;
        data_mux    = 1'b0;
        tag_we      = 1'b0;
        valid_set   = 1'b0;
        dirty_set   = 1'b0;
        dirty_clr   = 1'b0;
        busy        = 1'b1;

        case (r_state)
            c_LOOKUP: begin
                busy = 1'b0;
                if (cpu_req) begin
                    if (w_hit) begin
                        w_state_nxt = c_HIT;
                    end else if (c_WB && tag_valid && tag_dirty) begin
                        w_state_nxt = c_EVICT;
                    end else begin
                        w_state_nxt = c_REFILL;
                    end
                end
            end
            c_HIT: begin
                cpu_ready   = 1'b1;
                w_state_nxt = c_LOOKUP;
                if (cpu_we) begin
                    data_we = 1'b1;
                    if (c_WB) begin
                        dirty_set = 1'b1;
                    end else begin
                        w_state_nxt = c_WTHRU;
                    end
                end
            end
            c_WTHRU: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    w_state_nxt = c_LOOKUP;
                end
            end
            c_EVICT: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (w_last_ack) begin
                    w_state_nxt = c_REFILL;
                end
            end
            c_REFILL: begin
                mem_req  = 1'b1;
                data_mux = 1'b1;
                data_we  = mem_ack;
                if (w_last_ack) begin
                    w_state_nxt = c_UPDATE;
                end
            end
            c_UPDATE: begin
                tag_we      = 1'b1;
                valid_set   = 1'b1;
                dirty_clr   = c_WB;
                w_state_nxt = c_LOOKUP;
            end
            default: begin
                w_state_nxt = c_LOOKUP;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl_fsm
// Description : Directed bench for cache_ctrl_fsm; write-through (WB=0) and
//               write-back (WB=1) instances share stimulus, each checked
//               against a transaction-level model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_fsm;

    localparam int c_WPB = 4;
    localparam int c_CW  = 2;

    logic r_clk       = 1'b0;
    logic r_reset_n   = 1'b0;
    logic r_cpu_req   = 1'b0;
    logic r_cpu_we    = 1'b0;
    logic r_tag_match = 1'b0;
    logic r_tag_valid = 1'b0;
    logic r_tag_dirty = 1'b0;
    logic r_mem_ack   = 1'b0;

    // {cpu_ready, mem_req, mem_we, word_cnt[1:0], data_we, data_mux,
    //  tag_we, valid_set, dirty_set, dirty_clr, busy}
    wire [11:0] w_out [2];

    always #5 r_clk = ~r_clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            cache_ctrl_fsm #(
                .WORDS_PER_BLK(c_WPB),
                .CNT_W        (c_CW),
                .WRITE_BACK   (gi)
            ) u_dut (
                .clk      (r_clk),
                .reset_n  (r_reset_n),
                .cpu_req  (r_cpu_req),
                .cpu_we   (r_cpu_we),
                .tag_match(r_tag_match),
                .tag_valid(r_tag_valid),
                .tag_dirty(r_tag_dirty),
                .mem_ack  (r_mem_ack),
                .cpu_ready(w_out[gi][11]),
                .mem_req  (w_out[gi][10]),
                .mem_we   (w_out[gi][9]),
                .word_cnt (w_out[gi][8:7]),
                .data_we  (w_out[gi][6]),
                .data_mux (w_out[gi][5]),
                .tag_we   (w_out[gi][4]),
                .valid_set(w_out[gi][3]),
                .dirty_set(w_out[gi][2]),
                .dirty_clr(w_out[gi][1]),
                .busy     (w_out[gi][0])
            );
        end
    endgenerate

    // Transaction model: tracks which activity is outstanding and how many
    // block words remain, index 0 = write-through, 1 = write-back.
    int   m_evict_left  [2];
    int   m_refill_left [2];
    logic m_hit   [2];
    logic m_wthru [2];
    logic m_upd   [2];
    logic m_we    [2];

    always @(posedge r_clk or negedge r_reset_n) begin
        for (int m = 0; m < 2; m++) begin
            if (!r_reset_n) begin
                m_evict_left[m]  <= 0;
                m_refill_left[m] <= 0;
                m_hit[m]         <= 1'b0;
                m_wthru[m]       <= 1'b0;
                m_upd[m]         <= 1'b0;
                m_we[m]          <= 1'b0;
            end else if (m_hit[m]) begin
                m_hit[m] <= 1'b0;
                if (m_we[m] && (m == 0)) m_wthru[m] <= 1'b1;
            end else if (m_wthru[m]) begin
                if (r_mem_ack) m_wthru[m] <= 1'b0;
            end else if (m_evict_left[m] > 0) begin
                if (r_mem_ack) begin
                    m_evict_left[m] <= m_evict_left[m] - 1;
                    if (m_evict_left[m] == 1) m_refill_left[m] <= c_WPB;
                end
            end else if (m_refill_left[m] > 0) begin
                if (r_mem_ack) begin
                    m_refill_left[m] <= m_refill_left[m] - 1;
                    if (m_refill_left[m] == 1) m_upd[m] <= 1'b1;
                end
            end else if (m_upd[m]) begin
                m_upd[m] <= 1'b0;
            end else if (r_cpu_req) begin
                m_we[m] <= r_cpu_we;
                if (r_tag_match && r_tag_valid)
                    m_hit[m] <= 1'b1;
                else if ((m == 1) && r_tag_valid && r_tag_dirty)
                    m_evict_left[m] <= c_WPB;
                else
                    m_refill_left[m] <= c_WPB;
            end
        end
    end

    function automatic logic [11:0] f_expect(input int m);
        logic [11:0] e;
        int          wi;
        logic        xfer;
        e    = '0;
        wi   = 0;
        xfer = (m_evict_left[m] > 0) || (m_refill_left[m] > 0);
        if (m_evict_left[m] > 0)       wi = c_WPB - m_evict_left[m];
        else if (m_refill_left[m] > 0) wi = c_WPB - m_refill_left[m];
        e[11]  = m_hit[m];
        e[10]  = m_wthru[m] | xfer;
        e[9]   = m_wthru[m] | (m_evict_left[m] > 0);
        e[8:7] = wi[1:0];
        e[6]   = (m_hit[m] & m_we[m]) | ((m_refill_left[m] > 0) & r_mem_ack);
        e[5]   = (m_refill_left[m] > 0);
        e[4]   = m_upd[m];
        e[3]   = m_upd[m];
        e[2]   = m_hit[m] & m_we[m] & (m == 1);
        e[1]   = m_upd[m] & (m == 1);
        e[0]   = m_hit[m] | m_wthru[m] | xfer | m_upd[m];
        return e;
    endfunction

    int       n_checks = 0;
    int       n_fail   = 0;
    int       dwe_cnt   [2] = '{0, 0};
    int       tagwe_cnt [2] = '{0, 0};
    int       dclr_cnt  [2] = '{0, 0};
    int       rdy_cnt   [2] = '{0, 0};
    int       evw_cnt   [2] = '{0, 0};
    logic [7:0] dwe_seq [2] = '{8'h0, 8'h0};
    logic [7:0] ev_seq  [2] = '{8'h0, 8'h0};

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_cycle();
        logic [11:0] e;
        for (int m = 0; m < 2; m++) begin
            e = f_expect(m);
            n_checks++;
            if (w_out[m] !== e) begin
                n_fail++;
                $display("FAIL model_dut%0d t=%0t got=%b exp=%b", m, $time, w_out[m], e);
            end
            if (w_out[m][6]) begin
                dwe_cnt[m]++;
                dwe_seq[m] = {dwe_seq[m][5:0], w_out[m][8:7]};
            end
            if (w_out[m][9] && r_mem_ack) begin
                evw_cnt[m]++;
                ev_seq[m] = {ev_seq[m][5:0], w_out[m][8:7]};
            end
            if (w_out[m][4])  tagwe_cnt[m]++;
            if (w_out[m][1])  dclr_cnt[m]++;
            if (w_out[m][11]) rdy_cnt[m]++;
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked mid-cycle.
    task automatic step(input logic req, input logic we, input logic match,
                        input logic valid, input logic dirty, input logic ack);
        r_cpu_req   = req;
        r_cpu_we    = we;
        r_tag_match = match;
        r_tag_valid = valid;
        r_tag_dirty = dirty;
        r_mem_ack   = ack;
        @(negedge r_clk);
        check_cycle();
        @(posedge r_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_dwe0, s_dwe1, s_tw0, s_tw1, s_dc0, s_dc1, s_rdy0, s_ev1;
        logic [1:0] acks [7];
        acks = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset
        idle(2);
        lit("reset_out0", {20'h0, w_out[0]}, 32'h0);
        lit("reset_out1", {20'h0, w_out[1]}, 32'h0);
        r_reset_n = 1'b1;
        idle(1);

        // 1: read hit
        s_rdy0 = rdy_cnt[0];
        step(1, 0, 1, 1, 0, 0);
        lit("t1_ready", {31'h0, w_out[0][11]}, 32'h1);
        lit("t1_no_memreq", {31'h0, w_out[0][10]}, 32'h0);
        idle(2);
        lit("t1_ready_pulses", rdy_cnt[0] - s_rdy0, 32'd1);

        // 2: read miss, back-to-back acks, then re-lookup hits
        s_dwe0 = dwe_cnt[0]; s_tw0 = tagwe_cnt[0]; s_rdy0 = rdy_cnt[0];
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        lit("t2_update_tagwe", {31'h0, w_out[0][4]}, 32'h1);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0);
        idle(2);
        lit("t2_dwe_pulses", dwe_cnt[0] - s_dwe0, 32'd4);
        lit("t2_word_seq", {24'h0, dwe_seq[0]}, 32'h1B);
        lit("t2_tagwe_pulses", tagwe_cnt[0] - s_tw0, 32'd1);
        lit("t2_rehit_ready", rdy_cnt[0] - s_rdy0, 32'd1);

        // 3: dirty miss; WB=1 evicts then refills, WB=0 just refills
        s_dwe1 = dwe_cnt[1]; s_dc0 = dclr_cnt[0]; s_dc1 = dclr_cnt[1];
        s_ev1 = evw_cnt[1]; s_tw0 = tagwe_cnt[0];
        step(1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1);
        idle(2);
        lit("t3_evict_words", evw_cnt[1] - s_ev1, 32'd4);
        lit("t3_evict_seq", {24'h0, ev_seq[1]}, 32'h1B);
        lit("t3_refill_dwe", dwe_cnt[1] - s_dwe1, 32'd4);
        lit("t3_dirty_clr_wb", dclr_cnt[1] - s_dc1, 32'd1);
        lit("t3_dirty_clr_wt", dclr_cnt[0] - s_dc0, 32'd0);
        lit("t3_wt_one_update", tagwe_cnt[0] - s_tw0, 32'd1);

        // 4: write hit; WB=0 goes through WTHRU with a stalled ack
        step(1, 1, 1, 1, 0, 0);
        lit("t4_data_we", {31'h0, w_out[0][6]}, 32'h1);
        lit("t4_data_mux", {31'h0, w_out[0][5]}, 32'h0);
        lit("t4_dirty_set_wb", {31'h0, w_out[1][2]}, 32'h1);
        step(0, 1, 1, 1, 0, 0);
        lit("t4_wthru_memwe", {30'h0, w_out[0][10:9]}, 32'h3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        lit("t4_memreq_held", {31'h0, w_out[0][10]}, 32'h1);
        step(0, 0, 0, 0, 0, 1);
        lit("t4_back_idle", {31'h0, w_out[0][0]}, 32'h0);
        idle(1);

        // 5: refill with gapped acks
        s_dwe0 = dwe_cnt[0]; s_dwe1 = dwe_cnt[1];
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, acks[i][0]);
        lit("t5_update", {31'h0, w_out[0][4]}, 32'h1);
        idle(2);
        lit("t5_dwe0", dwe_cnt[0] - s_dwe0, 32'd4);
        lit("t5_dwe1", dwe_cnt[1] - s_dwe1, 32'd4);
        lit("t5_word_seq", {24'h0, dwe_seq[0]}, 32'h1B);

        // 6: reset during refill word 2
        s_tw0 = tagwe_cnt[0]; s_tw1 = tagwe_cnt[1];
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        lit("t6_word2", {30'h0, w_out[0][8:7]}, 32'd2);
        r_mem_ack = 1'b0;
        #2;
        r_reset_n = 1'b0;
        #1;
        lit("t6_rst_out0", {20'h0, w_out[0]}, 32'h0);
        lit("t6_rst_out1", {20'h0, w_out[1]}, 32'h0);
        idle(2);
        r_reset_n = 1'b1;
        idle(2);
        lit("t6_no_tagwe0", tagwe_cnt[0] - s_tw0, 32'd0);
        lit("t6_no_tagwe1", tagwe_cnt[1] - s_tw1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
